// File: rtl/vga_pkg.sv
// Shared VGA timing constants and pixel colour type.
// Used by VGA_Controller, SpriteCharacter and the sprite pipeline.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [23:0] TRANSPARENT_DEFAULT = 24'hFF00FF;

endpackage

// File: rtl/sprite_box_check.sv
// Sprite hit test and texel address generation for one raster position.
// Latency: combinational. Backpressure: none.
module sprite_box_check
  import vga_pkg::*;
#(
  parameter int SPRITE_W   = 32,
  parameter int SPRITE_H   = 32,
  parameter int SCALE_LOG2 = 0,
  parameter int ROM_AW     = 10
) (
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  input  logic [9:0]        x_l,
  input  logic [9:0]        y_l,
  output logic              in_box,
  output logic [ROM_AW-1:0] addr
);

  localparam logic [10:0] BOX_W = 11'(SPRITE_W << SCALE_LOG2);
  localparam logic [10:0] BOX_H = 11'(SPRITE_H << SCALE_LOG2);

  logic [10:0] dx;
  logic [10:0] dy;
  logic [9:0]  col;
  logic [9:0]  row;

  // 11-bit differences: bit 10 set means left of / above the sprite, so a
  // sprite hanging past the right or bottom edge can never wrap around.
  always_comb begin
    dx  = {1'b0, h_count} - {1'b0, x_l};
    dy  = {1'b0, v_count} - {1'b0, y_l};
    col = dx[9:0] >> SCALE_LOG2;
    row = dy[9:0] >> SCALE_LOG2;
    in_box = !dx[10] && !dy[10]
          && ({1'b0, dx[9:0]} < BOX_W)
          && ({1'b0, dy[9:0]} < BOX_H)
          && (h_count < 10'(H_VISIBLE))
          && (v_count < 10'(V_VISIBLE));
    addr = ROM_AW'(row * SPRITE_W + col);
  end

endmodule

// File: rtl/sprite_pixel_pipeline.sv
// Sprite renderer: raster counters in, texel colour and visibility out.
// Latency: 2 pix_en strobes; outputs hold between strobes. No backpressure.
module sprite_pixel_pipeline
  import vga_pkg::*;
#(
  parameter int          SPRITE_W    = 32,
  parameter int          SPRITE_H    = 32,
  parameter int          SCALE_LOG2  = 0,
  parameter logic [23:0] TRANSPARENT = TRANSPARENT_DEFAULT,
  parameter int          LATCH_LINE  = 480,
  parameter int          ROM_AW      = 10
) (
  input  logic              FPGA_Clock,
  input  logic              SwitchReset,
  input  logic              pix_en,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  input  logic [9:0]        X_POS,
  input  logic [9:0]        Y_POS,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic [23:0]       RGB_Sprite,
  output logic              visible_Sprite,
  output logic [9:0]        h_out,
  output logic [9:0]        v_out
);

  logic [9:0]        x_l;
  logic [9:0]        y_l;
  logic              in_box;
  logic [ROM_AW-1:0] addr_c;
  logic              in_box_q;
  logic [9:0]        h_q;
  logic [9:0]        v_q;
  logic              s1_vld;
  rgb_t              texel_q;

  sprite_box_check #(
    .SPRITE_W   (SPRITE_W),
    .SPRITE_H   (SPRITE_H),
    .SCALE_LOG2 (SCALE_LOG2),
    .ROM_AW     (ROM_AW)
  ) u_box (
    .h_count (h_count),
    .v_count (v_count),
    .x_l     (x_l),
    .y_l     (y_l),
    .in_box  (in_box),
    .addr    (addr_c)
  );

  always_ff @(posedge FPGA_Clock) begin
    if (SwitchReset) begin
      x_l            <= '0;
      y_l            <= '0;
      in_box_q       <= 1'b0;
      h_q            <= '0;
      v_q            <= '0;
      s1_vld         <= 1'b0;
      texel_q        <= '0;
      rom_addr       <= '0;
      RGB_Sprite     <= '0;
      visible_Sprite <= 1'b0;
      h_out          <= '0;
      v_out          <= '0;
    end else begin
      // ROM answers one clock after the address moves, before the next strobe.
      s1_vld <= pix_en;
      if (s1_vld) begin
        texel_q <= rom_data;
      end
      if (pix_en) begin
        if (v_count == 10'(LATCH_LINE) && h_count == 10'd0) begin
          x_l <= X_POS;
          y_l <= Y_POS;
        end
        in_box_q <= in_box;
        h_q      <= h_count;
        v_q      <= v_count;
        if (in_box) begin
          rom_addr <= addr_c;
        end
        RGB_Sprite     <= in_box_q ? 24'(texel_q) : 24'd0;
        visible_Sprite <= in_box_q && (24'(texel_q) != TRANSPARENT);
        h_out          <= h_q;
        v_out          <= v_q;
      end
    end
  end

endmodule

// File: tb/tb_sprite_pixel_pipeline.sv
// Directed bench for sprite_pixel_pipeline with a per-cycle reference model.
module tb_sprite_pixel_pipeline;

  typedef struct packed {
    logic [23:0] rgb;
    logic        vis;
    logic [9:0]  h;
    logic [9:0]  v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic [9:0]  h_count = '0;
  logic [9:0]  v_count = '0;
  logic [9:0]  x_pos = '0;
  logic [9:0]  y_pos = '0;

  logic [9:0]  rom_addr1, rom_addr2;
  logic [23:0] rom_data1, rom_data2;
  logic [23:0] rgb1, rgb2;
  logic        vis1, vis2;
  logic [9:0]  h_out1, v_out1, h_out2, v_out2;

  logic [23:0] mem [1024];

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  assign rom_data1 = mem[rom_addr1];
  assign rom_data2 = mem[rom_addr2];

  sprite_pixel_pipeline dut1 (
    .FPGA_Clock(clk), .SwitchReset(rst), .pix_en(pix_en),
    .h_count(h_count), .v_count(v_count), .X_POS(x_pos), .Y_POS(y_pos),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .RGB_Sprite(rgb1),
    .visible_Sprite(vis1), .h_out(h_out1), .v_out(v_out1)
  );

  sprite_pixel_pipeline #(.SCALE_LOG2(1)) dut2 (
    .FPGA_Clock(clk), .SwitchReset(rst), .pix_en(pix_en),
    .h_count(h_count), .v_count(v_count), .X_POS(x_pos), .Y_POS(y_pos),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .RGB_Sprite(rgb2),
    .visible_Sprite(vis2), .h_out(h_out2), .v_out(v_out2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // What the screen must show at (h,v) for a sprite latched at (x,y).
  function automatic exp_t px(input int h, input int v, input int x, input int y, input int s);
    exp_t e;
    int dx, dy;
    dx = h - x;
    dy = v - y;
    e.h = 10'(h);
    e.v = 10'(v);
    e.rgb = '0;
    e.vis = 1'b0;
    if (h < 640 && v < 480 && dx >= 0 && dy >= 0 && dx < (32 << s) && dy < (32 << s)) begin
      e.rgb = mem[(dy >> s) * 32 + (dx >> s)];
      e.vis = (e.rgb != 24'hFF00FF);
    end
    return e;
  endfunction

  exp_t pend1, pend2, exp1, exp2;
  int   xm, ym;
  bit   mdl_on = 1'b0;
  bit   pe_d = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      pend1 <= '0; pend2 <= '0; exp1 <= '0; exp2 <= '0;
      xm <= 0; ym <= 0;
      mdl_on <= 1'b1;
    end else if (pix_en) begin
      exp1  <= pend1;
      exp2  <= pend2;
      pend1 <= px(int'(h_count), int'(v_count), xm, ym, 0);
      pend2 <= px(int'(h_count), int'(v_count), xm, ym, 1);
      if (v_count == 10'd480 && h_count == 10'd0) begin
        xm <= int'(x_pos);
        ym <= int'(y_pos);
      end
    end
  end

  always @(posedge clk) begin
    assert (!(pix_en && pe_d)) else $error("pix_en high on consecutive cycles");
    pe_d <= pix_en;
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("model_rgb", 32'(rgb1), 32'(exp1.rgb));
      chk("model_vis", 32'(vis1), 32'(exp1.vis));
      chk("model_h",   32'(h_out1), 32'(exp1.h));
      chk("model_v",   32'(v_out1), 32'(exp1.v));
      chk("model2_rgb", 32'(rgb2), 32'(exp2.rgb));
      chk("model2_vis", 32'(vis2), 32'(exp2.vis));
      chk("model2_h",   32'(h_out2), 32'(exp2.h));
    end
  end

  task automatic strobe(input int h, input int v);
    @(negedge clk);
    h_count = 10'(h);
    v_count = 10'(v);
    pix_en  = 1'b1;
    @(negedge clk);
    pix_en  = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [23:0] rgb, input logic vis,
                            input int h, input int v);
    chk({name, "_rgb"}, 32'(rgb1), 32'(rgb));
    chk({name, "_vis"}, 32'(vis1), 32'(vis));
    chk({name, "_h"},   32'(h_out1), 32'(h));
    chk({name, "_v"},   32'(v_out1), 32'(v));
  endtask

  task automatic latch_pos(input int x, input int y);
    x_pos = 10'(x);
    y_pos = 10'(y);
    strobe(0, 480);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 24'h100000 + 24'(a * 3);
    mem[0]  = 24'h123456;
    mem[33] = 24'hFF00FF;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_out("reset", 24'h0, 1'b0, 0, 0);
    chk("reset_rom_addr", 32'(rom_addr1), 32'd0);

    // Scale: position is (0,0) until the first latch.
    strobe(3, 5);
    chk("addr_scale1", 32'(rom_addr2), 32'd65);
    chk("addr_scale0", 32'(rom_addr1), 32'd163);
    strobe(4, 5);
    expect_out("pre_reset", 24'h100000 + 24'(163 * 3), 1'b1, 3, 5);

    // Reset in the middle of a line.
    @(negedge clk);
    h_count = 10'd100;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_out("midline_reset", 24'h0, 1'b0, 0, 0);
    chk("midline_reset_addr", 32'(rom_addr1), 32'd0);
    strobe(5, 5);
    expect_out("after_rst_1", 24'h0, 1'b0, 0, 0);
    strobe(6, 5);
    expect_out("after_rst_2", 24'h100000 + 24'(165 * 3), 1'b1, 5, 5);

    // Basic hit and transparency.
    latch_pos(152, 40);
    strobe(152, 40);
    strobe(153, 41);
    expect_out("basic_hit", 24'h123456, 1'b1, 152, 40);
    strobe(0, 0);
    expect_out("transparent", 24'hFF00FF, 1'b0, 153, 41);

    // Position changes mid-frame take effect only at the latch line.
    x_pos = 10'd300;
    strobe(0, 200);
    strobe(152, 40);
    strobe(0, 0);
    expect_out("frame_hold", 24'h123456, 1'b1, 152, 40);
    strobe(0, 480);
    strobe(300, 40);
    strobe(152, 40);
    expect_out("frame_new", 24'h123456, 1'b1, 300, 40);
    strobe(0, 0);
    expect_out("frame_old", 24'h0, 1'b0, 152, 40);

    // Right-edge clip with no wrap.
    latch_pos(630, 40);
    strobe(635, 40);
    strobe(641, 40);
    expect_out("clip_in", 24'h100000 + 24'(5 * 3), 1'b1, 635, 40);
    strobe(0, 41);
    expect_out("clip_641", 24'h0, 1'b0, 641, 40);
    strobe(1, 41);
    expect_out("clip_wrap", 24'h0, 1'b0, 0, 41);

    // Bottom-edge clip and off-screen position.
    latch_pos(10, 470);
    strobe(10, 479);
    strobe(10, 480);
    expect_out("clip_bot_in", 24'h100000 + 24'(9 * 32 * 3), 1'b1, 10, 479);
    strobe(10, 0);
    expect_out("clip_bot_out", 24'h0, 1'b0, 10, 480);
    latch_pos(700, 40);
    strobe(639, 40);
    strobe(0, 0);
    expect_out("offscreen_x", 24'h0, 1'b0, 639, 40);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
